dt_scan_ctrl: RTL

- Memory-mapped controller for the 8-digit seven-segment display tube (DT). It sits directly downstream of the system bridge.
- Takes the bridge's per-byte write enables, the word address and the store data. Holds a DATA register and a CTRL register, and returns read data on the DT read-data path.
- Time-multiplexes the eight digits with a free-running scan divider. Drives registered, active-low digit-select and segment lines to the board.

---
 rtl/dt_scan_ctrl_if.sv | 22 ++
 rtl/dt_scan_ctrl.sv | 109 ++++++++++
 2 files changed

// File: rtl/dt_scan_ctrl_if.sv
// Bus interface between the system bridge and the display-tube scan controller.
// The bridge side drives address, byte enables and store data and receives read data.
interface dt_scan_ctrl_if;
    logic [31:0] addr;
    logic [3:0]  byteEn;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (
        output addr,
        output byteEn,
        output wdata,
        input  rdata
    );

    modport slave (
        input  addr,
        input  byteEn,
        input  wdata,
        output rdata
    );
endinterface

// File: rtl/dt_scan_ctrl.sv
// Seven-segment display tube controller: DATA/CTRL registers written over the
// bridge bus, plus a free-running scan that multiplexes eight active-low digits.
module dt_scan_ctrl #(
    parameter int SCAN_DIV = 50000,
    parameter int DIGITS   = 8
) (
    input  logic               clk,
    input  logic               reset,
    dt_scan_ctrl_if.slave      bus,
    output logic [7:0]         sel_n,
    output logic [7:0]         seg_n
);

    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam int IDX_W = $clog2(DIGITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    logic [31:0]      data;
    logic [15:0]      ctrl;
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] idx;

    logic       scan_wrap;
    logic [7:0] en_mask;
    logic [7:0] dp_mask;
    logic [3:0] cur_nibble;
    logic       cur_en;
    logic       cur_dp;
    logic       unused_addr_bits;

    // Seven-segment code for one hex nibble, gfedcba, active-low.
    function automatic logic [6:0] hexcode(input logic [3:0] nib);
        logic [6:0] code;
        case (nib)
            4'h0: code = 7'h40;
            4'h1: code = 7'h79;
            4'h2: code = 7'h24;
            4'h3: code = 7'h30;
            4'h4: code = 7'h19;
            4'h5: code = 7'h12;
            4'h6: code = 7'h02;
            4'h7: code = 7'h78;
            4'h8: code = 7'h00;
            4'h9: code = 7'h10;
            4'hA: code = 7'h08;
            4'hB: code = 7'h03;
            4'hC: code = 7'h46;
            4'hD: code = 7'h21;
            4'hE: code = 7'h06;
            default: code = 7'h0E;
        endcase
        return code;
    endfunction

    assign scan_wrap  = (cnt == CNT_LAST);
    assign en_mask    = ctrl[7:0];
    assign dp_mask    = ctrl[15:8];
    assign cur_nibble = data[{idx, 2'b00} +: 4];
    assign cur_en     = en_mask[idx];
    assign cur_dp     = dp_mask[idx];

    // Only addr[2] selects a register; the remaining bits are decoded upstream.
    assign unused_addr_bits = &{1'b0, bus.addr[31:3], bus.addr[1:0]};

    // Read mux: upper half of CTRL has no storage and reads as zero.
    assign bus.rdata = bus.addr[2] ? {16'b0, ctrl} : data;

    // Register file: per-byte writes into DATA or the implemented low half of CTRL.
    always_ff @(posedge clk) begin
        if (reset) begin
            data <= 32'h0000_0000;
            ctrl <= 16'h00FF;
        end else if (!bus.addr[2]) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.byteEn[i]) data[8*i +: 8] <= bus.wdata[8*i +: 8];
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (bus.byteEn[i]) ctrl[8*i +: 8] <= bus.wdata[8*i +: 8];
            end
        end
    end

    // Scan divider: hold each digit for SCAN_DIV cycles, then step to the next one.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
            idx <= '0;
        end else if (scan_wrap) begin
            cnt <= '0;
            idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Registered board drive built from the pre-edge digit index and register contents.
    always_ff @(posedge clk) begin
        if (reset) begin
            sel_n <= 8'hFF;
            seg_n <= 8'hFF;
        end else begin
            sel_n <= ~(8'b1 << idx);
            seg_n <= {~(cur_en & cur_dp), cur_en ? hexcode(cur_nibble) : 7'h7F};
        end
    end

endmodule
